// File: rtl/tms_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tms_arb_pkg
// Description : Shared constants and FSM state type for the TMS1x00
//               program-memory arbiter (register offsets, memory window,
//               starvation limit).
// Revision    : 1.0 - initial release
// ============================================================================
package tms_arb_pkg;

  // Register offsets relative to the block's Wishbone base address
  localparam logic [31:0] CTRL_OFFSET   = 32'h0000_8000;
  localparam logic [31:0] STATUS_OFFSET = 32'h0000_8004;
  localparam logic [31:0] STALLS_OFFSET = 32'h0000_8008;

  // Offsets below this limit map onto program RAM (one byte per word)
  localparam logic [31:0] MEM_LIMIT     = 32'h0000_2000;

  // Contested cycles a Wishbone access may lose before it is forced through
  localparam logic [3:0]  STARVE_LIMIT  = 4'd8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_GRANT = 2'd1,
    MEM        = 2'd2,
    ACK        = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/tms_prog_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tms_prog_mem_arbiter
// Description : Shares one single-port synchronous program RAM between the
//               Wishbone slave (program load/verify, CTRL/STATUS registers)
//               and the TMS1x00 instruction-fetch port. Holds the core in
//               reset until RUN is set. Fetch has priority; a starvation
//               guard forces a Wishbone access through after STARVE_LIMIT
//               lost cycles.
//               Optional macro ARB_STATS_EN adds the STALLS counter at 0x8008.
// Revision    : 1.0 - initial release
// ============================================================================
module tms_prog_mem_arbiter
  import tms_arb_pkg::*;
#(
  parameter int          ADDR_W    = 11,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              rst_n,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              core_fetch_req_i,
  input  logic [ADDR_W-1:0] core_fetch_addr_i,
  output logic [7:0]        core_fetch_data_o,
  output logic              core_fetch_valid_o,
  output logic              core_rst_n_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i
);

  arb_state_t        state;
  arb_state_t        state_next;
  logic [31:0]       offset;
  logic              is_mem;
  logic              accept;
  logic              wb_pending;
  logic              starve_hit;
  logic              wb_grant;
  logic              core_grant;
  logic              wb_stall;
  logic              ctrl_run;
  logic              fetch_inflight;
  logic [3:0]        starve_cnt;
  logic [ADDR_W-1:0] wb_addr;
  logic              wb_we;
  logic [7:0]        wb_wdata;
  logic [31:0]       rdata;
  logic [31:0]       reg_rdata;
  logic              unused_bits;

`ifdef ARB_STATS_EN
  logic [15:0]       stall_cnt;
`endif

  assign offset     = wbs_adr_i - BASE_ADDR;
  assign is_mem     = (offset < MEM_LIMIT);
  assign accept     = (state == IDLE) && wbs_cyc_i && wbs_stb_i;
  assign wb_pending = (state == WAIT_GRANT);
  assign starve_hit = (starve_cnt >= STARVE_LIMIT);
  assign wb_stall   = wb_pending && !wb_grant;

  // A fetch granted last cycle is only presented while the core is running,
  // so clearing RUN drops any valid that is still in flight.
  assign core_fetch_valid_o = fetch_inflight && core_rst_n_o;
  assign core_fetch_data_o  = mem_rdata_i;

  // Upper byte lanes and sel bits are not used by this byte-wide block
  assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:8], STALLS_OFFSET};

  // Register read mux; sampled when the access is accepted
  always_comb begin
    reg_rdata = '0;
    if (offset == CTRL_OFFSET) begin
      reg_rdata = {31'd0, ctrl_run};
    end else if (offset == STATUS_OFFSET) begin
      reg_rdata = {24'd0, starve_cnt, 2'd0, wb_pending, core_rst_n_o};
`ifdef ARB_STATS_EN
    end else if (offset == STALLS_OFFSET) begin
      reg_rdata = {16'd0, stall_cnt};
`endif
    end
  end

  // FSM state register
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Arbitration, next state, RAM port and Wishbone response
  always_comb begin
    state_next  = state;
    wbs_ack_o   = 1'b0;
    wbs_dat_o   = '0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = core_fetch_addr_i;
    mem_wdata_o = '0;
    wb_grant    = wb_pending && (!core_rst_n_o || !core_fetch_req_i || starve_hit);
    core_grant  = core_rst_n_o && core_fetch_req_i && !wb_grant;
    case (state)
      IDLE:       if (accept) state_next = is_mem ? WAIT_GRANT : ACK;
      WAIT_GRANT: if (wb_grant) state_next = MEM;
      MEM:        state_next = ACK;
      ACK: begin
        state_next = IDLE;
        wbs_ack_o  = 1'b1;
        wbs_dat_o  = rdata;
      end
      default:    state_next = IDLE;
    endcase
    if (wb_grant) begin
      mem_en_o    = 1'b1;
      mem_we_o    = wb_we;
      mem_addr_o  = wb_addr;
      mem_wdata_o = wb_wdata;
    end else if (core_grant) begin
      mem_en_o    = 1'b1;
    end
  end

  // Request capture, read data, CTRL, core reset, fetch tracking, starve count
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wb_addr        <= '0;
      wb_we          <= 1'b0;
      wb_wdata       <= '0;
      rdata          <= '0;
      ctrl_run       <= 1'b0;
      core_rst_n_o   <= 1'b0;
      fetch_inflight <= 1'b0;
      starve_cnt     <= '0;
    end else begin
      if (accept) begin
        wb_addr  <= offset[ADDR_W+1:2];
        wb_we    <= wbs_we_i && wbs_sel_i[0];
        wb_wdata <= wbs_dat_i[7:0];
        rdata    <= is_mem ? 32'd0 : reg_rdata;
        if (wbs_we_i && wbs_sel_i[0] && (offset == CTRL_OFFSET)) begin
          ctrl_run <= wbs_dat_i[0];
        end
      end else if (state == MEM) begin
        rdata <= {24'd0, mem_rdata_i};
      end
      core_rst_n_o   <= ctrl_run;
      fetch_inflight <= core_grant;
      if (wb_grant) begin
        starve_cnt <= '0;
      end else if (wb_stall && (starve_cnt != 4'hF)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

`ifdef ARB_STATS_EN
  // Saturating count of Wishbone stall cycles; any write to STALLS clears it
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (accept && wbs_we_i && (offset == STALLS_OFFSET)) begin
      stall_cnt <= '0;
    end else if (wb_stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire
